// File: rtl/mining_job_scheduler.sv
// Mining job scheduler: accepts jobs into a one-deep pending slot, loads them
// into the active payload registers, holds the solver in reset, runs it under
// a watchdog and reports found / aborted / exhausted / timeout results.
module mining_job_scheduler #(
    parameter int unsigned RESET_HOLD = 4,
    parameter logic [31:0] WATCHDOG   = 32'd50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] midstate_in,
    input  logic [95:0]  leftovers_in,
    input  logic [255:0] target_in,
    output logic [255:0] midstate_out,
    output logic [95:0]  leftovers_out,
    output logic [255:0] target_out,
    output logic         solver_rst_n,
    input  logic [2:0]   solver_state,
    input  logic [31:0]  solver_nonce,
    input  logic         abort,
    output logic         result_valid,
    input  logic         result_ack,
    output logic [1:0]   result_status,
    output logic [31:0]  result_nonce,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_REPORT
    } state_t;

    localparam logic [1:0] ST_ABORT   = 2'b00;
    localparam logic [1:0] ST_FOUND   = 2'b01;
    localparam logic [1:0] ST_EXHAUST = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    state_t        r_state;
    state_t        w_next;

    logic          r_slot_full;
    logic [255:0]  r_slot_mid;
    logic [95:0]   r_slot_left;
    logic [255:0]  r_slot_tgt;

    logic [255:0]  r_mid;
    logic [95:0]   r_left;
    logic [255:0]  r_tgt;

    logic [31:0]   r_hold_cnt;
    logic [31:0]   r_wdog;
    logic [31:0]   r_prev;
    logic [1:0]    r_status;
    logic [31:0]   r_nonce;

    logic          w_xfer;
    logic          w_slot_clr;
    logic          w_first;
    logic          w_found;
    logic          w_wrap;
    logic          w_tmo;
    logic          w_set_res;
    logic [1:0]    w_res_status;
    logic [31:0]   w_res_nonce;
    logic          w_unused_state;

    // Low solver_state bits carry no meaning for scheduling.
    assign w_unused_state = ^solver_state[1:0];

    // An abort in the same cycle blocks any incoming job.
    assign job_ready = !r_slot_full && !abort;
    assign w_xfer    = job_valid && job_ready;

    // Watchdog is zero only in the first RUN cycle, so it doubles as the
    // "no previous nonce yet" marker.
    assign w_first = (r_wdog == 32'd0);
    assign w_found = solver_state[2];
    assign w_wrap  = !w_first && (solver_nonce < r_prev);
    assign w_tmo   = (r_wdog == WATCHDOG - 32'd1);

    assign result_valid  = (r_state == S_REPORT);
    assign busy          = (r_state == S_LOAD) || (r_state == S_HOLD) || (r_state == S_RUN);
    assign solver_rst_n  = (r_state == S_RUN);
    assign result_status = r_status;
    assign result_nonce  = r_nonce;
    assign midstate_out  = r_mid;
    assign leftovers_out = r_left;
    assign target_out    = r_tgt;

    // Next-state, slot-clear and result selection.
    always_comb begin
        w_next       = r_state;
        w_slot_clr   = 1'b0;
        w_set_res    = 1'b0;
        w_res_status = ST_ABORT;
        w_res_nonce  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (abort)            w_slot_clr = 1'b1;
                else if (r_slot_full) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_slot_clr = 1'b1;
                if (abort) begin
                    w_next    = S_REPORT;
                    w_set_res = 1'b1;
                end else begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    w_slot_clr = 1'b1;
                    w_next     = S_REPORT;
                    w_set_res  = 1'b1;
                end else if (r_hold_cnt == RESET_HOLD - 1) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_found) begin
                    w_next       = S_REPORT;
                    w_set_res    = 1'b1;
                    w_res_status = ST_FOUND;
                    w_res_nonce  = solver_nonce;
                end else if (abort) begin
                    w_slot_clr = 1'b1;
                    w_next     = S_REPORT;
                    w_set_res  = 1'b1;
                end else if (w_wrap) begin
                    w_next       = S_REPORT;
                    w_set_res    = 1'b1;
                    w_res_status = ST_EXHAUST;
                    w_res_nonce  = r_prev;
                end else if (w_tmo) begin
                    w_next       = S_REPORT;
                    w_set_res    = 1'b1;
                    w_res_status = ST_TIMEOUT;
                    w_res_nonce  = solver_nonce;
                end
            end
            S_REPORT: begin
                if (abort) w_slot_clr = 1'b1;
                if (result_ack) w_next = (r_slot_full && !abort) ? S_LOAD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Pending slot: filled on transfer, emptied on load or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_full <= 1'b0;
            r_slot_mid  <= '0;
            r_slot_left <= '0;
            r_slot_tgt  <= '0;
        end else if (w_slot_clr) begin
            r_slot_full <= 1'b0;
        end else if (w_xfer) begin
            r_slot_full <= 1'b1;
            r_slot_mid  <= midstate_in;
            r_slot_left <= leftovers_in;
            r_slot_tgt  <= target_in;
        end
    end

    // Active payload changes only in LOAD so the solver sees a stable job.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mid  <= '0;
            r_left <= '0;
            r_tgt  <= '0;
        end else if (r_state == S_LOAD) begin
            r_mid  <= r_slot_mid;
            r_left <= r_slot_left;
            r_tgt  <= r_slot_tgt;
        end
    end

    // HOLD length counter, idle at zero outside HOLD.
    always_ff @(posedge clk) begin
        if (reset)                  r_hold_cnt <= 32'd0;
        else if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 32'd1;
        else                        r_hold_cnt <= 32'd0;
    end

    // Watchdog and previous nonce track RUN cycles; watchdog restarts each job.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= 32'd0;
            r_prev <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_wdog <= r_wdog + 32'd1;
            r_prev <= solver_nonce;
        end else begin
            r_wdog <= 32'd0;
        end
    end

    // Result registers are captured on the way into REPORT and held after.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= 2'b00;
            r_nonce  <= 32'd0;
        end else if (w_set_res) begin
            r_status <= w_res_status;
            r_nonce  <= w_res_nonce;
        end
    end

endmodule

// File: tb/tb_mining_job_scheduler.sv
// Bench for mining_job_scheduler: a cycle-level job model checked every cycle
// against the main instance, plus directed literal checks; a second instance
// with a short watchdog covers the timeout path.
module tb_mining_job_scheduler;
    localparam int          RH = 4;
    localparam logic [31:0] WD = 32'd50_000_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1, job_valid = 1'b0, abort = 1'b0, result_ack = 1'b0;
    logic [255:0] midstate_in = '0, target_in = '0;
    logic [95:0]  leftovers_in = '0;
    logic [2:0]   solver_state = '0;
    logic [31:0]  solver_nonce = '0;

    logic         job_ready, solver_rst_n, result_valid, busy;
    logic [255:0] midstate_out, target_out;
    logic [95:0]  leftovers_out;
    logic [1:0]   result_status;
    logic [31:0]  result_nonce;

    logic         t_job_ready, t_solver_rst_n, t_result_valid, t_busy;
    logic [255:0] t_midstate_out, t_target_out;
    logic [95:0]  t_leftovers_out;
    logic [1:0]   t_result_status;
    logic [31:0]  t_result_nonce;

    mining_job_scheduler #(.RESET_HOLD(RH)) u_dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .midstate_in(midstate_in), .leftovers_in(leftovers_in), .target_in(target_in),
        .midstate_out(midstate_out), .leftovers_out(leftovers_out), .target_out(target_out),
        .solver_rst_n(solver_rst_n), .solver_state(solver_state), .solver_nonce(solver_nonce),
        .abort(abort), .result_valid(result_valid), .result_ack(result_ack),
        .result_status(result_status), .result_nonce(result_nonce), .busy(busy));

    mining_job_scheduler #(.RESET_HOLD(RH), .WATCHDOG(32'd16)) u_dut16 (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(t_job_ready),
        .midstate_in(midstate_in), .leftovers_in(leftovers_in), .target_in(target_in),
        .midstate_out(t_midstate_out), .leftovers_out(t_leftovers_out), .target_out(t_target_out),
        .solver_rst_n(t_solver_rst_n), .solver_state(solver_state), .solver_nonce(solver_nonce),
        .abort(abort), .result_valid(t_result_valid), .result_ack(result_ack),
        .result_status(t_result_status), .result_nonce(t_result_nonce), .busy(t_busy));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural job model ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_REPORT = 4;
    int           m_ph = P_IDLE;
    int           m_hold_left = 0;
    longint       m_run = 0;
    logic         m_slot_full = 1'b0;
    logic [255:0] m_smid = '0, m_stgt = '0, m_amid = '0, m_atgt = '0;
    logic [95:0]  m_slft = '0, m_alft = '0;
    logic [31:0]  m_prev = '0, m_nonce = '0;
    logic [1:0]   m_status = '0;

    task automatic m_report(input logic [1:0] st, input logic [31:0] n);
        m_status = st;
        m_nonce  = n;
    endtask

    always @(posedge clk) begin : model
        bit clr;
        int np;
        clr = 1'b0;
        np  = m_ph;
        if (reset) begin
            m_ph = P_IDLE; m_slot_full = 1'b0; m_run = 0; m_prev = '0;
            m_amid = '0; m_alft = '0; m_atgt = '0; m_status = '0; m_nonce = '0;
        end else begin
            case (m_ph)
                P_IDLE: if (abort) clr = 1'b1; else if (m_slot_full) np = P_LOAD;
                P_LOAD: begin
                    m_amid = m_smid; m_alft = m_slft; m_atgt = m_stgt;
                    clr = 1'b1;
                    if (abort) begin np = P_REPORT; m_report(2'b00, 32'd0); end
                    else begin np = P_HOLD; m_hold_left = RH; end
                end
                P_HOLD: begin
                    if (abort) begin clr = 1'b1; np = P_REPORT; m_report(2'b00, 32'd0); end
                    else begin
                        m_hold_left--;
                        if (m_hold_left == 0) begin np = P_RUN; m_run = 0; end
                    end
                end
                P_RUN: begin
                    if (solver_state[2]) begin np = P_REPORT; m_report(2'b01, solver_nonce); end
                    else if (abort) begin clr = 1'b1; np = P_REPORT; m_report(2'b00, 32'd0); end
                    else if (m_run != 0 && solver_nonce < m_prev) begin np = P_REPORT; m_report(2'b10, m_prev); end
                    else if (m_run == longint'(WD) - 1) begin np = P_REPORT; m_report(2'b11, solver_nonce); end
                    m_prev = solver_nonce;
                    m_run++;
                end
                default: begin
                    if (abort) clr = 1'b1;
                    if (result_ack) np = (m_slot_full && !abort) ? P_LOAD : P_IDLE;
                end
            endcase
            if (clr) m_slot_full = 1'b0;
            else if (job_valid && !m_slot_full && !abort) begin
                m_slot_full = 1'b1;
                m_smid = midstate_in; m_slft = leftovers_in; m_stgt = target_in;
            end
            m_ph = np;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        chk("job_ready", 256'(job_ready), 256'(!m_slot_full && !abort));
        chk("busy", 256'(busy), 256'(m_ph == P_LOAD || m_ph == P_HOLD || m_ph == P_RUN));
        chk("solver_rst_n", 256'(solver_rst_n), 256'(m_ph == P_RUN));
        chk("result_valid", 256'(result_valid), 256'(m_ph == P_REPORT));
        chk("result_status", 256'(result_status), 256'(m_status));
        chk("result_nonce", 256'(result_nonce), 256'(m_nonce));
        chk("midstate_out", midstate_out, m_amid);
        chk("leftovers_out", 256'(leftovers_out), 256'(m_alft));
        chk("target_out", target_out, m_atgt);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [31:0] seed);
        midstate_in  = {8{seed}};
        leftovers_in = {3{~seed}};
        target_in    = {8{seed ^ 32'h5A5A_0F0F}};
        job_valid    = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    // Steps until solver_rst_n rises; returns busy-but-reset cycles (LOAD + HOLD).
    task automatic wait_run(output int cnt);
        int i;
        cnt = 0;
        for (i = 0; i < 60 && !solver_rst_n; i++) begin
            if (busy) cnt++;
            tick();
        end
        if (!solver_rst_n) chk("wait_run_timeout", 256'(0), 256'(1));
    endtask

    task automatic ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        tick(); tick();
        chk("reset_ready", 256'(job_ready), 256'(1));
        chk("reset_busy", 256'(busy), 256'(0));
        reset = 1'b0;
        tick();

        // Single job, found after 100 RUN cycles.
        offer(32'hA000_0001);
        wait_run(cnt);
        chk("load_plus_hold_cycles", 256'(cnt), 256'(1 + RH));
        chk("payload_A", midstate_out, {8{32'hA000_0001}});
        for (int i = 0; i < 100; i++) begin solver_nonce = 32'(i + 1); tick(); end
        solver_state = 3'b100; solver_nonce = 32'h0000_1234;
        tick();
        solver_state = 3'b000;
        chk("found_valid", 256'(result_valid), 256'(1));
        chk("found_status", 256'(result_status), 256'(2'b01));
        chk("found_nonce", 256'(result_nonce), 256'(32'h1234));
        tick(); tick();
        chk("report_stable", 256'(result_nonce), 256'(32'h1234));
        ack();

        // Queued job: B offered during A's RUN.
        offer(32'hB000_000A);
        wait_run(cnt);
        solver_nonce = 32'd5;  // lower than the previous job's last nonce
        tick();
        offer(32'hB000_000B);
        chk("ready_after_B", 256'(job_ready), 256'(0));
        tick();
        chk("A_not_preempted", midstate_out, {8{32'hB000_000A}});
        solver_state = 3'b100; solver_nonce = 32'd55;
        tick();
        solver_state = 3'b000;
        chk("A_found", 256'(result_nonce), 256'(32'd55));
        ack();
        chk("B_load_busy", 256'(busy), 256'(1));
        chk("B_load_payload_A", midstate_out, {8{32'hB000_000A}});
        tick();
        chk("B_payload_out", midstate_out, {8{32'hB000_000B}});

        // Exhaustion on B.
        wait_run(cnt);
        solver_nonce = 32'hFFFF_FFFF; tick();
        solver_nonce = 32'h0000_0000; tick();
        chk("exhaust_status", 256'(result_status), 256'(2'b10));
        chk("exhaust_nonce", 256'(result_nonce), 256'(32'hFFFF_FFFF));
        ack();

        // Abort and find in the same RUN cycle, with a pending job.
        offer(32'hC000_000C);
        wait_run(cnt);
        solver_nonce = 32'd10;
        offer(32'hD000_000D);
        abort = 1'b1; solver_state = 3'b100; solver_nonce = 32'd77;
        tick();
        abort = 1'b0; solver_state = 3'b000;
        chk("simul_status", 256'(result_status), 256'(2'b01));
        chk("simul_nonce", 256'(result_nonce), 256'(32'd77));
        chk("simul_slot_kept", 256'(job_ready), 256'(0));
        ack();      // LOAD of D
        tick();     // first HOLD cycle
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("hold_abort_status", 256'(result_status), 256'(2'b00));
        chk("hold_abort_nonce", 256'(result_nonce), 256'(0));
        ack();
        chk("idle_after_abort", 256'(busy), 256'(0));
        chk("slot_empty", 256'(job_ready), 256'(1));

        // job_valid together with abort is ignored; stray ack is ignored.
        midstate_in = {8{32'hEEEE_0000}};
        job_valid = 1'b1; abort = 1'b1;
        tick();
        job_valid = 1'b0; abort = 1'b0;
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("no_job_taken", 256'(busy), 256'(0));
        chk("stray_ack", 256'(result_valid), 256'(0));

        // Plain abort during RUN.
        offer(32'hE000_000E);
        wait_run(cnt);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("run_abort_status", 256'(result_status), 256'(2'b00));
        ack();

        // Reset mid-RUN with the slot full.
        offer(32'hF000_000F);
        wait_run(cnt);
        offer(32'hF000_0010);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_ready", 256'(job_ready), 256'(1));
        chk("rst_valid", 256'(result_valid), 256'(0));
        chk("rst_solver", 256'(solver_rst_n), 256'(0));
        chk("rst_payload", midstate_out, 256'(0));
        tick(); tick(); tick();
        chk("rst_pending_dropped", 256'(busy), 256'(0));

        // Timeout on the short-watchdog instance.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        solver_nonce = 32'd0;
        offer(32'h7100_0016);
        for (int i = 0; i < 60 && !t_solver_rst_n; i++) tick();
        cnt = 0;
        for (int i = 0; i < 40 && !t_result_valid; i++) begin tick(); cnt++; end
        chk("timeout_cycles", 256'(cnt), 256'(16));
        chk("timeout_status", 256'(t_result_status), 256'(2'b11));
        chk("timeout_nonce", 256'(t_result_nonce), 256'(0));
        ack();
        reset = 1'b1; tick(); reset = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
